// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the 8N1 UART core.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int HALF_TICKS = OVERSAMPLE / 2;
   localparam int TICK_W     = $clog2(OVERSAMPLE);
   localparam int BIT_W      = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_HOLD
   } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// Host-side and serial-pin signals of the UART core, with host (master) and core (slave) views.
interface uart_if #(parameter int DIV_W = 16) ();
   import uart_pkg::*;

   logic [DIV_W-1:0]     baud_division;
   logic                 en;
   logic [DATA_BITS-1:0] ext_data_in;
   logic                 rx;
   logic                 tx;
   logic [DATA_BITS-1:0] ext_data_out;
   logic                 rx_valid;
   logic                 tx_busy;
   logic                 baud_tick;

   modport master (
      output baud_division, en, ext_data_in, rx,
      input  tx, ext_data_out, rx_valid, tx_busy, baud_tick
   );

   modport slave (
      input  baud_division, en, ext_data_in, rx,
      output tx, ext_data_out, rx_valid, tx_busy, baud_tick
   );

endinterface

// File: rtl/uart_baud_rate.sv
// Oversample strobe generator: one tick every baud_division clocks while run is high.
module uart_baud_rate #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] division,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] last;

   // Divisors 0 and 1 both collapse to a tick on every running clock.
   assign last = (div_q <= DIV_W'(1)) ? '0 : div_q - DIV_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         div_q <= '0;
         tick  <= 1'b0;
      end else if (!run) begin
         cnt   <= '0;
         div_q <= division;
         tick  <= 1'b0;
      end else if (cnt >= last) begin
         cnt   <= '0;
         div_q <= division;
         tick  <= 1'b1;
      end else begin
         cnt   <= cnt + DIV_W'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronised line, mid-bit sampling, glitch reject and framing check.
module uart_rx
   import uart_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 busy
);

   rx_state_t            state, state_nx;
   logic [1:0]           sync;
   logic                 rxs;
   logic [TICK_W-1:0]    tcnt;
   logic [BIT_W-1:0]     bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 tick_last;
   logic                 tick_half;

   assign rxs       = sync[1];
   assign tick_last = tick && (tcnt == TICK_W'(OVERSAMPLE - 1));
   assign tick_half = tick && (tcnt == TICK_W'(HALF_TICKS - 1));

   // Synchroniser resets to the idle level so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync <= 2'b11;
      else      sync <= {sync[0], rx};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RX_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RX_IDLE:  if (!rxs) state_nx = RX_START;
         RX_START: if (tick_half) state_nx = rxs ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick_last && bidx == BIT_W'(DATA_BITS - 1)) state_nx = RX_STOP;
         RX_STOP:  if (tick_last) state_nx = rxs ? RX_IDLE : RX_HOLD;
         RX_HOLD:  if (rxs) state_nx = RX_IDLE;
         default:  state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt  <= '0;
         bidx  <= '0;
         shreg <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            RX_IDLE: begin
               tcnt <= '0;
               bidx <= '0;
            end
            RX_START: if (tick) tcnt <= tick_half ? '0 : tcnt + TICK_W'(1);
            RX_DATA: if (tick) begin
               tcnt <= tick_last ? '0 : tcnt + TICK_W'(1);
               if (tick_last) begin
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  bidx  <= bidx + BIT_W'(1);
               end
            end
            RX_STOP: if (tick) begin
               tcnt <= tick_last ? '0 : tcnt + TICK_W'(1);
               // A low stop bit is a framing error: the byte is dropped.
               if (tick_last && rxs) begin
                  data  <= shreg;
                  valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = (state != RX_IDLE);
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, LSB-first data, stop bit, each OVERSAMPLE ticks long.
module uart_tx
   import uart_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 en,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy
);

   tx_state_t            state, state_nx;
   logic                 pending;
   logic [TICK_W-1:0]    tcnt;
   logic [BIT_W-1:0]     bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 tick_last;

   assign tick_last = tick && (tcnt == TICK_W'(OVERSAMPLE - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= TX_IDLE;
      else      state <= state_nx;
   end

   // NOTE: default assignment first so no path through this block leaves state_nx unassigned (no latch).
   always_comb begin
      state_nx = state;
      case (state)
         TX_IDLE:  if (pending && tick) state_nx = TX_START;
         TX_START: if (tick_last) state_nx = TX_DATA;
         TX_DATA:  if (tick_last && bidx == BIT_W'(DATA_BITS - 1)) state_nx = TX_STOP;
         TX_STOP:  if (tick_last) state_nx = TX_IDLE;
         default:  state_nx = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
         tcnt    <= '0;
         bidx    <= '0;
         shreg   <= '0;
      end else if (state == TX_IDLE) begin
         tcnt <= '0;
         bidx <= '0;
         // Pending remembers a short en pulse until the next tick starts the frame.
         if (pending && tick) begin
            shreg   <= data;
            pending <= 1'b0;
         end else if (en) begin
            pending <= 1'b1;
         end
      end else if (tick) begin
         tcnt <= tick_last ? '0 : tcnt + TICK_W'(1);
         if (state == TX_DATA && tick_last) begin
            shreg <= shreg >> 1;
            bidx  <= bidx + BIT_W'(1);
         end
      end
   end

   always_comb begin
      busy = (state != TX_IDLE) || pending || en;
      case (state)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = shreg[0];
         default:  tx = 1'b1;
      endcase
   end

endmodule

// File: rtl/uart_core.sv
// UART core top: shared baud generator, transmitter and receiver behind the uart_if slave port.
module uart_core
   import uart_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic clk,
   input  logic rst,
   uart_if.slave bus
);

   logic tick;
   logic tx_busy;
   logic rx_busy;
   logic run;

   // tx_busy already folds in the pending request and en while idle.
   assign run = bus.en | tx_busy | rx_busy;

   uart_baud_rate #(.DIV_W(DIV_W)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .division (bus.baud_division),
      .tick     (tick)
   );

   uart_tx u_tx (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .en   (bus.en),
      .data (bus.ext_data_in),
      .tx   (bus.tx),
      .busy (tx_busy)
   );

   uart_rx u_rx (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .rx    (bus.rx),
      .data  (bus.ext_data_out),
      .valid (bus.rx_valid),
      .busy  (rx_busy)
   );

   assign bus.baud_tick = tick;
   assign bus.tx_busy   = tx_busy;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: tx looped to rx, plus hand-driven rx frames for error cases.
module tb_uart_core;
   import uart_pkg::*;

   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic loop   = 1'b1;
   logic rx_drv = 1'b1;
   int   checks    = 0;
   int   passed    = 0;
   int   valid_cnt = 0;
   int   base      = 0;
   int   cnt       = 0;
   logic [7:0] d;

   uart_if bus ();

   assign bus.rx = loop ? bus.tx : rx_drv;

   uart_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #25 clk = ~clk;

   always @(negedge clk) if (bus.rx_valid === 1'b1) valid_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for a start bit on tx, then samples every bit at its centre.
   task automatic capture(input string tag, input int bit_clk, output logic [7:0] data);
      int n = 0;
      data = '0;
      while (bus.tx !== 1'b0 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_start_seen"}, 32'(n < 30000), 1);
      clks(bit_clk / 2);
      check({tag, "_start_bit"}, bus.tx, 0);
      for (int i = 0; i < 8; i++) begin
         clks(bit_clk);
         data[i] = bus.tx;
      end
      clks(bit_clk);
      check({tag, "_stop_bit"}, bus.tx, 1);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int bit_clk);
      rx_drv = 1'b0;
      clks(bit_clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         clks(bit_clk);
      end
      rx_drv = stop;
      clks(bit_clk);
      rx_drv = 1'b1;
      clks(bit_clk);
   endtask

   task automatic wait_busy_low(input string tag, input int budget);
      int n = 0;
      while (bus.tx_busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < budget), 1);
   endtask

   task automatic count_tx_low(input int n, output int lows);
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) lows++;
      end
   endtask

   initial begin
      #4900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.baud_division = 16'd130;
      bus.en            = 1'b0;
      bus.ext_data_in   = 8'h00;

      #60;
      check("rst_tx",       bus.tx,           1);
      check("rst_data_out", bus.ext_data_out, 0);
      check("rst_rx_valid", bus.rx_valid,     0);
      check("rst_tx_busy",  bus.tx_busy,      0);
      check("rst_tick",     bus.baud_tick,    0);
      @(negedge clk);
      rst = 1'b1;

      cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.baud_tick === 1'b1) cnt++;
      end
      check("idle_no_tick", cnt, 0);

      // Frame 0xB4 with en held; data changes to 0xF1 mid-frame.
      base = valid_cnt;
      bus.ext_data_in = 8'hB4;
      bus.en = 1'b1;
      fork
         capture("f1", 2080, d);
         begin
            clks(5000);
            bus.ext_data_in = 8'hF1;
         end
      join
      check("f1_tx_byte", d, 8'hB4);
      clks(100);
      check("f1_rx_out",   bus.ext_data_out, 8'hB4);
      check("f1_rx_valid", valid_cnt - base, 1);

      // Back-to-back frame picks up 0xF1; en drops mid-frame.
      fork
         capture("f2", 2080, d);
         begin
            clks(8000);
            bus.en = 1'b0;
         end
      join
      check("f2_tx_byte", d, 8'hF1);
      clks(900);
      check("f2_busy_in_stop", bus.tx_busy, 1);
      wait_busy_low("f2_busy_fall", 400);
      check("f2_rx_out",   bus.ext_data_out, 8'hF1);
      check("f2_rx_valid", valid_cnt - base, 2);
      count_tx_low(3000, cnt);
      check("f2_no_third_frame", cnt, 0);

      // Two-clock en pulse sends exactly one frame.
      base = valid_cnt;
      bus.ext_data_in = 8'hA5;
      bus.en = 1'b1;
      clks(2);
      bus.en = 1'b0;
      capture("f3", 2080, d);
      check("f3_tx_byte", d, 8'hA5);
      clks(100);
      check("f3_rx_out",   bus.ext_data_out, 8'hA5);
      check("f3_rx_valid", valid_cnt - base, 1);
      wait_busy_low("f3_busy_fall", 1500);
      count_tx_low(2000, cnt);
      check("f3_single_frame", cnt, 0);

      // Short low glitch on rx is rejected at the start-bit centre.
      loop = 1'b0;
      base = valid_cnt;
      rx_drv = 1'b0;
      clks(200);
      rx_drv = 1'b1;
      clks(3000);
      check("glitch_rx_out",   bus.ext_data_out, 8'hA5);
      check("glitch_rx_valid", valid_cnt - base, 0);

      // Faster divider for hand-driven frames: bit = 20 * 16 = 320 clocks.
      bus.baud_division = 16'd20;
      clks(10);
      send_rx(8'h3C, 1'b0, 320);
      clks(500);
      check("ferr_rx_out",   bus.ext_data_out, 8'hA5);
      check("ferr_rx_valid", valid_cnt - base, 0);

      send_rx(8'h5A, 1'b1, 320);
      clks(50);
      check("good_rx_out",   bus.ext_data_out, 8'h5A);
      check("good_rx_valid", valid_cnt - base, 1);
      check("tx_idle_high",  bus.tx, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
